// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   state_t    : clear-sequencer FSM states (ST_INIT zeroes the array, ST_RUN is normal operation)
//   ZeroWord   : all-zero data constant, sliced to XLEN by users (XLEN up to MAX_XLEN)
//   port_lsb() : bit offset of port j inside a flattened multi-port bus of w-bit fields
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MAX_XLEN = 128;
    localparam logic [MAX_XLEN-1:0] ZeroWord = '0;

    // Flattened buses pack port j at [j*w +: w]; all slicing goes through this.
    function automatic int port_lsb(input int j, input int w);
        return j * w;
    endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port select logic for the register file.
// Ports:
//   active     in   high only in RUN with reset released; otherwise the port reads 0
//   re         in   read enable of this port
//   raddr      in   read address of this port
//   we         in   NWR write enables
//   waddr      in   NWR*AW flattened write addresses
//   wdata      in   NWR*XLEN flattened write data
//   array_data in   stored value at raddr
//   rdata      out  selected read data
module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 1
) (
    input  logic                active,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [XLEN-1:0]     array_data,
    output logic [XLEN-1:0]     rdata
);

    logic            hit;
    logic [XLEN-1:0] fwd;

    always_comb begin
        hit = 1'b0;
        fwd = ZeroWord[XLEN-1:0];
        // Ascending scan: the highest-index matching write port ends up selected,
        // matching the port that wins the array write on a same-address conflict.
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[port_lsb(j, AW) +: AW] == raddr)) begin
                hit = 1'b1;
                fwd = wdata[port_lsb(j, XLEN) +: XLEN];
            end
        end

        if (!active || !re || (raddr == '0)) begin
            rdata = ZeroWord[XLEN-1:0];
        end else if (hit) begin
            rdata = fwd;
        end else begin
            rdata = array_data;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with issue scoreboard and clear sequencer.
// Register 0 reads as zero and is never written or marked busy. The storage
// array has no reset: after reset or a clear request the sequencer writes one
// zero per cycle for NREG cycles, during which ready is low.
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   clear_req  start a clear sequence (honoured only when ready)
//   ready      high while the array is valid and writes are accepted
//   we/waddr/wdata   NWR write ports (flattened, port j at [j*W +: W])
//   re/raddr/rdata   NRD combinational read ports with write forwarding
//   sb_set/sb_addr   mark a register busy (result pending)
//   busy       per-register busy bits, bit 0 constant 0
// Handshake: no valid/ready pairing on individual ports; writes and sb_set are
// accepted on every edge where ready is high and ignored otherwise.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),  // derived, leave at default
    parameter int NRD  = 2,
    parameter int NWR  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_req,
    output logic                ready,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic [NREG-1:0]     busy
);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_next;
    logic [XLEN-1:0] regs [NREG];
    logic            run_active;

    assign run_active = (state == ST_RUN) && !rst;
    assign busy       = busy_q;

    // Scoreboard update for a RUN cycle without clear: writebacks release
    // their destination first, then a new issue claims sb_addr, so a producer
    // issued in the same cycle as an older writeback keeps the register busy.
    always_comb begin
        busy_next = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[port_lsb(j, AW) +: AW] != '0)) begin
                busy_next[waddr[port_lsb(j, AW) +: AW]] = 1'b0;
            end
        end
        if (sb_set && (sb_addr != '0)) begin
            busy_next[sb_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Clear sequencer FSM with registered ready and scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_INIT;
            cnt    <= '0;
            ready  <= 1'b0;
            busy_q <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    busy_q <= '0;
                    cnt    <= cnt + 1'b1;
                    if (cnt == AW'(NREG - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state  <= ST_INIT;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        busy_q <= '0;
                    end else begin
                        busy_q <= busy_next;
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    cnt    <= '0;
                    ready  <= 1'b0;
                    busy_q <= '0;
                end
            endcase
        end
    end

    // Storage array, no reset. While rst is high the state is already INIT,
    // so the only activity is harmless zeroing. Writes in the clear_req cycle
    // still commit because the state is RUN for that edge. Later ports
    // overwrite earlier ones, so the highest-index port wins a conflict.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            regs[cnt] <= ZeroWord[XLEN-1:0];
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (waddr[port_lsb(j, AW) +: AW] != '0)) begin
                    regs[waddr[port_lsb(j, AW) +: AW]] <= wdata[port_lsb(j, XLEN) +: XLEN];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[i*AW +: AW];

        regfile_fwd_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_mux (
            .active     (run_active),
            .re         (re[i]),
            .raddr      (ra),
            .we         (we),
            .waddr      (waddr),
            .wdata      (wdata),
            .array_data (regs[ra]),
            .rdata      (rdata[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk;
  logic                rst;
  logic                clear_req;
  logic                ready;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [NREG-1:0]     busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_busy;
  bit              m_run;
  int              m_left;

  regfile_mp #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .ready     (ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .busy      (busy)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected read value straight from the read rules: zero when not running,
  // disabled or x0; otherwise the last-listed write to that address this
  // cycle, else the stored value.
  function automatic logic [XLEN-1:0] m_read(input int i);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = raddr[i*AW +: AW];
    if (rst || !m_run || !re[i] || a == 0) return '0;
    v = m_regs[a];
    for (int j = 0; j < NWR; j++)
      if (we[j] && waddr[j*AW +: AW] == a) v = wdata[j*XLEN +: XLEN];
    return v;
  endfunction

  task automatic m_update();
    if (rst) begin
      m_run = 0; m_left = NREG; m_busy = '0;
      for (int r = 0; r < NREG; r++) m_regs[r] = '0;
    end else if (!m_run) begin
      m_left--;
      if (m_left == 0) m_run = 1;
    end else begin
      logic [NREG-1:0] nb;
      nb = m_busy;
      for (int j = 0; j < NWR; j++) begin
        int a;
        a = int'(waddr[j*AW +: AW]);
        if (we[j] && a != 0) begin
          m_regs[a] = wdata[j*XLEN +: XLEN];
          nb[a] = 1'b0;
        end
      end
      if (sb_set && sb_addr != 0) nb[sb_addr] = 1'b1;
      if (clear_req) begin
        // array is observed again only after the full clear, when it is all zero
        m_run = 0; m_left = NREG; nb = '0;
        for (int r = 0; r < NREG; r++) m_regs[r] = '0;
      end
      m_busy = nb;
    end
  endtask

  // driver tasks
  task automatic sample();
    @(negedge clk);
    for (int i = 0; i < NRD; i++)
      check($sformatf("rdata%0d", i), 64'(rdata[i*XLEN +: XLEN]), 64'(m_read(i)));
    check("busy", 64'(busy), rst ? 64'd0 : 64'(m_busy));
    check("ready", 64'(ready), 64'(!rst && m_run));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic idle();
    clear_req = 0; we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0; sb_set = 0; sb_addr = '0;
  endtask

  task automatic drive_random(input bit allow_clear);
    we        = NWR'($urandom_range(0, (1 << NWR) - 1));
    waddr     = NWR*AW'($urandom);
    wdata     = {$urandom, $urandom};
    re        = NRD'($urandom_range(0, (1 << NRD) - 1));
    raddr     = NRD*AW'($urandom);
    sb_set    = 1'($urandom_range(0, 1));
    sb_addr   = AW'($urandom);
    clear_req = allow_clear ? ($urandom_range(0, 99) == 0) : 1'b0;
  endtask

  // Random traffic while counting edges until ready is seen; clear_req is
  // also pulsed during INIT to show it is ignored there.
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    forever begin
      drive_random(1'b0);
      if (k < NREG) clear_req = 1'($urandom_range(0, 1));
      else clear_req = 0;
      sample();
      if (ready || k >= 100) break;
      clock_edge();
      k++;
    end
    check(tag, 64'(k), 64'(NREG));
    idle();
    clock_edge();
  endtask

  initial begin
    m_busy = '0; m_run = 0; m_left = NREG;
    for (int r = 0; r < NREG; r++) m_regs[r] = '0;
    idle();
    rst = 1;
    re = '1; raddr = {5'd3, 5'd1};
    repeat (3) begin sample(); clock_edge(); end
    rst = 0;

    wait_ready("ready_after_reset");

    // basic write with forwarding, then array read
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
    re = 2'b01; raddr = {5'd0, 5'd5};
    sample(); check("fwd_5", 64'(rdata[31:0]), 64'hDEADBEEF);
    clock_edge();
    idle(); re = 2'b10; raddr = {5'd5, 5'd0};
    sample(); check("array_5", 64'(rdata[63:32]), 64'hDEADBEEF);
    clock_edge();

    // x0 protection
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h1234};
    re = 2'b11; raddr = {5'd0, 5'd0}; sb_set = 1; sb_addr = 5'd0;
    sample(); check("x0_fwd", 64'(rdata[31:0]), 64'h0);
    clock_edge();
    idle(); re = 2'b01;
    sample(); check("x0_read", 64'(rdata[31:0]), 64'h0); check("x0_busy", 64'(busy[0]), 64'h0);
    clock_edge();

    // same-address conflict: port 1 wins
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'hBBBB, 32'hAAAA};
    re = 2'b01; raddr = {5'd0, 5'd7};
    sample(); check("conflict_fwd", 64'(rdata[31:0]), 64'hBBBB);
    clock_edge();
    idle(); re = 2'b01; raddr = {5'd0, 5'd7};
    sample(); check("conflict_array", 64'(rdata[31:0]), 64'hBBBB);
    clock_edge();

    // scoreboard set, clear, and set-over-clear
    sb_set = 1; sb_addr = 5'd3;
    sample(); clock_edge();
    idle();
    sample(); check("sb_set_r3", 64'(busy[3]), 64'h1);
    clock_edge();
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
    sample(); clock_edge();
    idle();
    sample(); check("sb_clr_r3", 64'(busy[3]), 64'h0);
    clock_edge();
    we = 2'b10; waddr = {5'd3, 5'd0}; wdata = {32'h77, 32'h0}; sb_set = 1; sb_addr = 5'd3;
    sample(); clock_edge();
    idle(); re = 2'b01; raddr = {5'd0, 5'd3};
    sample(); check("sb_both_busy", 64'(busy[3]), 64'h1); check("sb_both_data", 64'(rdata[31:0]), 64'h77);
    clock_edge();

    // flush: r9 loaded and busy, then clear_req
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h55}; sb_set = 1; sb_addr = 5'd9;
    sample(); clock_edge();
    idle(); clear_req = 1; re = 2'b01; raddr = {5'd0, 5'd9};
    sample(); check("flush_pre_r9", 64'(rdata[31:0]), 64'h55); check("flush_pre_busy", 64'(busy[9]), 64'h1);
    clock_edge();
    wait_ready("ready_after_flush");
    re = 2'b11; raddr = {5'd9, 5'd9};
    sample(); check("flush_r9", 64'(rdata[31:0]), 64'h0); check("flush_busy", 64'(busy), 64'h0);
    clock_edge();

    // reset at cnt=10 restarts the whole sequence
    idle(); clear_req = 1;
    sample(); clock_edge();
    idle();
    repeat (10) begin sample(); clock_edge(); end
    rst = 1;
    sample(); clock_edge();
    rst = 0;
    wait_ready("ready_after_mid_reset");

    // randomized traffic with occasional flush and reset
    for (int n = 0; n < 3000; n++) begin
      drive_random(1'b1);
      if (n > 0 && $urandom_range(0, 499) == 0) rst = 1;
      else rst = 0;
      waddr = waddr & {NWR{5'h0F}};
      raddr = raddr & {NRD{5'h0F}};
      sb_addr = sb_addr & 5'h0F;
      sample();
      clock_edge();
    end
    rst = 0;
    idle();
    sample();
    clock_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
